// File: rtl/branch_pkg.sv
// Shared definitions for the branch-resolution stage: condition codes, FSM states, flag vector.
package branch_pkg;

    localparam logic [2:0] COND_BEQ   = 3'b000;
    localparam logic [2:0] COND_BNE   = 3'b001;
    localparam logic [2:0] COND_BLT   = 3'b010;
    localparam logic [2:0] COND_BGT   = 3'b011;
    localparam logic [2:0] COND_BLE   = 3'b100;
    localparam logic [2:0] COND_BGE   = 3'b101;
    localparam logic [2:0] COND_JMP   = 3'b110;
    localparam logic [2:0] COND_NEVER = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StRedirect
    } state_t;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } flags_t;

    function automatic logic flags_onehot(flags_t f);
        return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: (cond, eq, lt, gt) -> (taken, err).
module cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       eq,
    input  logic       lt,
    input  logic       gt,
    output logic       taken,
    output logic       err
);

    flags_t flags;
    logic   raw;
    logic   uncond;

    assign flags  = '{eq: eq, lt: lt, gt: gt};
    assign uncond = (cond == COND_JMP) || (cond == COND_NEVER);

    always_comb begin
        raw = 1'b0;
        case (cond)
            COND_BEQ:   raw = eq;
            COND_BNE:   raw = !eq;
            COND_BLT:   raw = lt;
            COND_BGT:   raw = gt;
            COND_BLE:   raw = lt | eq;
            COND_BGE:   raw = gt | eq;
            COND_JMP:   raw = 1'b1;
            default:    raw = 1'b0;
        endcase
    end

    // Corrupt comparator flags make any flag-dependent decision meaningless.
    assign err   = !uncond && !flags_onehot(flags);
    assign taken = raw && !err;

endmodule

// File: rtl/branch_resolve.sv
// Branch-resolution stage owning the PC; optional taken counter under BRANCH_STATS_EN.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int unsigned AW = 10,
    parameter int unsigned OW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    cond,
    input  logic [OW-1:0] offset,
    input  logic          eq,
    input  logic          lt,
    input  logic          gt,
    input  logic          pc_advance,
    output logic [AW-1:0] pc,
    output logic          flush,
    output logic          flag_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]   taken_cnt
`endif
);

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [2:0]    cond_q;
    logic [OW-1:0] offset_q;
    flags_t        flags_q;
    logic          taken;
    logic          err;

    // Sign-extend through a wide intermediate so AW == OW needs no zero-width replication.
    logic [AW+OW-1:0] off_wide;
    logic [AW-1:0]    off_ext;
    assign off_wide = {{AW{offset_q[OW-1]}}, offset_q};
    assign off_ext  = off_wide[AW-1:0];

    cond_eval u_cond_eval (
        .cond  (cond_q),
        .eq    (flags_q.eq),
        .lt    (flags_q.lt),
        .gt    (flags_q.gt),
        .taken (taken),
        .err   (err)
    );

`ifdef BRANCH_STATS_EN
    logic [15:0] cnt_q;
    assign taken_cnt = cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            cond_q   <= COND_NEVER;
            offset_q <= '0;
            flags_q  <= '0;
`ifdef BRANCH_STATS_EN
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        cond_q   <= cond;
                        offset_q <= offset;
                        flags_q  <= '{eq: eq, lt: lt, gt: gt};
                        state_q  <= StEval;
                    end else if (pc_advance) begin
                        pc_q <= pc_q + AW'(1);
                    end
                end
                StEval: begin
                    if (taken) begin
                        pc_q    <= pc_q + off_ext;
                        state_q <= StRedirect;
`ifdef BRANCH_STATS_EN
                        cnt_q   <= cnt_q + 16'd1;
`endif
                    end else begin
                        pc_q    <= pc_q + AW'(1);
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready = (state_q == StIdle);
    assign flush    = (state_q == StRedirect);
    assign flag_err = (state_q == StEval) && err;
    assign pc       = pc_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with an expected-result scoreboard queue.
module tb_branch_resolve;

    localparam int AW = 10;
    localparam int OW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    cond;
    logic [OW-1:0] offset;
    logic          eq, lt, gt;
    logic          pc_advance;
    logic [AW-1:0] pc;
    logic          flush;
    logic          flag_err;
`ifdef BRANCH_STATS_EN
    logic [15:0]   taken_cnt;
`endif

    branch_resolve #(.AW(AW), .OW(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cond       (cond),
        .offset     (offset),
        .eq         (eq),
        .lt         (lt),
        .gt         (gt),
        .pc_advance (pc_advance),
        .pc         (pc),
        .flush      (flush),
        .flag_err   (flag_err)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt  (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic          taken;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            tests_run = 0;
    int            tests_failed = 0;
    logic [AW-1:0] exp_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        pc_advance = 1'b0;
        rst_n      = 1'b0;
        #2;
        rst_n      = 1'b1;
        exp_pc     = '0;
        step();
    endtask

    task automatic advance(input int n, input string tag);
        pc_advance = 1'b1;
        repeat (n) step();
        pc_advance = 1'b0;
        exp_pc = exp_pc + AW'(n);
        check(tag, 32'(pc), 32'(exp_pc));
    endtask

    // Drive one branch request at cycle T and check T+1, T+2 and (if taken) T+3.
    task automatic branch(input logic [2:0] c, input logic signed [OW-1:0] off,
                          input logic e, input logic l, input logic g,
                          input logic adv, input string tag);
        exp_t item;
        exp_t got;
        logic raw;
        int   ones;
        ones = int'(e) + int'(l) + int'(g);
        case (c)
            3'd0: raw = e;
            3'd1: raw = !e;
            3'd2: raw = l;
            3'd3: raw = g;
            3'd4: raw = l || e;
            3'd5: raw = g || e;
            3'd6: raw = 1'b1;
            default: raw = 1'b0;
        endcase
        item.err   = (c < 3'd6) && (ones != 1);
        item.taken = raw && !item.err;
        item.pc    = item.taken ? exp_pc + AW'(off) : exp_pc + AW'(1);
        sb.push_back(item);

        cond = c; offset = off; eq = e; lt = l; gt = g;
        in_valid = 1'b1; pc_advance = adv;
        step();
        // T+1: in EVAL; flag changes now must not affect the branch
        in_valid = 1'b0;
        eq = ~e; lt = ~l; gt = ~g;
        check({tag, ".eval_ready"}, 32'(in_ready), 32'd0);
        check({tag, ".flag_err"}, 32'(flag_err), 32'(item.err));
        check({tag, ".eval_flush"}, 32'(flush), 32'd0);
        step();
        // T+2
        pc_advance = 1'b0;
        got = sb.pop_front();
        check({tag, ".pc"}, 32'(pc), 32'(got.pc));
        check({tag, ".flush"}, 32'(flush), 32'(got.taken));
        check({tag, ".ready"}, 32'(in_ready), 32'(!got.taken));
        check({tag, ".err_pulse"}, 32'(flag_err), 32'd0);
        exp_pc = got.pc;
        if (got.taken) begin
            step();
            check({tag, ".ready3"}, 32'(in_ready), 32'd1);
            check({tag, ".flush3"}, 32'(flush), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; pc_advance = 1'b0;
        cond = '0; offset = '0; eq = 1'b0; lt = 1'b0; gt = 1'b0;
        exp_pc = '0;
        #12;
        check("rst.pc", 32'(pc), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd1);
        check("rst.flush", 32'(flush), 32'd0);
        check("rst.flag_err", 32'(flag_err), 32'd0);
`ifdef BRANCH_STATS_EN
        check("rst.cnt", 32'(taken_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        step();
        advance(3, "adv3");
        advance(2, "adv5");
        branch(3'b000, 10'sd4, 1'b1, 1'b0, 1'b0, 1'b0, "beq_taken");

        do_reset();
        advance(8, "adv8");
        branch(3'b010, -10'sd3, 1'b0, 1'b0, 1'b1, 1'b0, "blt_nt");

        do_reset();
        advance(1020, "adv1020");
        branch(3'b110, 10'sd10, 1'b0, 1'b0, 1'b0, 1'b0, "jmp_wrap_up");
        advance(1020, "adv_to2");
        branch(3'b110, -10'sd5, 1'b0, 1'b0, 1'b0, 1'b0, "jmp_wrap_dn");

        branch(3'b101, 10'sd7, 1'b1, 1'b0, 1'b1, 1'b0, "bge_illegal");
        branch(3'b000, 10'sd3, 1'b1, 1'b0, 1'b0, 1'b1, "beq_with_adv");
        branch(3'b001, 10'sd9, 1'b1, 1'b0, 1'b0, 1'b1, "bne_nt_adv");
        branch(3'b100, 10'sd2, 1'b0, 1'b1, 1'b0, 1'b0, "ble_taken");
        branch(3'b011, 10'sd2, 1'b0, 1'b1, 1'b0, 1'b0, "bgt_nt");
        branch(3'b111, 10'sd2, 1'b1, 1'b1, 1'b1, 1'b0, "never");

        // Reset pulsed during EVAL of a taken JMP
        cond = 3'b110; offset = 10'sd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst.pc", 32'(pc), 32'd0);
        check("midrst.ready", 32'(in_ready), 32'd1);
        check("midrst.flush", 32'(flush), 32'd0);
        #1;
        rst_n = 1'b1;
        exp_pc = '0;
        step();
        check("midrst.pc2", 32'(pc), 32'd0);
        check("midrst.flush2", 32'(flush), 32'd0);

        do_reset();
        branch(3'b110, 10'sd1, 1'b0, 1'b0, 1'b0, 1'b0, "st1");
        branch(3'b111, 10'sd1, 1'b0, 1'b0, 1'b0, 1'b0, "st2");
        branch(3'b000, 10'sd1, 1'b1, 1'b0, 1'b0, 1'b0, "st3");
        branch(3'b010, 10'sd1, 1'b0, 1'b0, 1'b1, 1'b0, "st4");
        branch(3'b011, 10'sd1, 1'b0, 1'b0, 1'b1, 1'b0, "st5");
`ifdef BRANCH_STATS_EN
        check("stats.cnt", 32'(taken_cnt), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
